// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported external memory between the instruction fetch (IF)
// stage and the data (MEM) stage. Each access runs as a Mem_Req/Mem_Ack
// handshake. The winning requester gets its read data plus a one-cycle Ready
// pulse. Data accesses win ties. A burst counter bounds how many data grants
// can pass a waiting fetch, so fetch cannot be starved forever.
//
// Ports
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   IF_Read/IF_Address  fetch request (level, held until IF_Ready) and address
//   IF_DataOut/IF_Ready fetched word and its one-cycle completion pulse
//   IF_Wait             fetch stall: IF_Read & ~IF_Ready
//   DM_Read/DM_Write    load/store request (level); a store wins if both are set
//   DM_Address          data word address
//   DM_WriteData        store data
//   DM_ByteEn           store byte enables
//   DM_DataOut/DM_Ready load data and its one-cycle completion pulse
//   DM_Wait             data stall: (DM_Read|DM_Write) & ~DM_Ready
//   Mem_*               external memory request side; Mem_ReadData is valid
//                       with the one-cycle Mem_Ack
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_DM_BURST = 4   // 1..15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // fetch side
  input  logic                  IF_Read,
  input  logic [ADDR_WIDTH-1:0] IF_Address,
  output logic [DATA_WIDTH-1:0] IF_DataOut,
  output logic                  IF_Ready,
  output logic                  IF_Wait,
  // data side
  input  logic                  DM_Read,
  input  logic                  DM_Write,
  input  logic [ADDR_WIDTH-1:0] DM_Address,
  input  logic [DATA_WIDTH-1:0] DM_WriteData,
  input  logic [3:0]            DM_ByteEn,
  output logic [DATA_WIDTH-1:0] DM_DataOut,
  output logic                  DM_Ready,
  output logic                  DM_Wait,
  // external memory
  output logic                  Mem_Req,
  output logic                  Mem_Write,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_WriteData,
  output logic [3:0]            Mem_ByteEn,
  input  logic [DATA_WIDTH-1:0] Mem_ReadData,
  input  logic                  Mem_Ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

  state_t     state_reg, state_next;
  logic [3:0] burst_cnt_reg, burst_cnt_next;

  logic dm_req;
  logic dm_grant;
  logic if_grant;
  logic if_done;
  logic dm_done;

  assign dm_req = DM_Read | DM_Write;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // Data wins in IDLE unless it has already taken BURST_MAX grants in a row
  // while a fetch was waiting. RESP never grants, so a requester that still
  // holds its request during the Ready pulse is not served twice.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (dm_req && ((burst_cnt_reg < BURST_MAX) || !IF_Read)) begin
          state_next = BUSY_DM;
        end else if (IF_Read) begin
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (Mem_Ack) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (grant and completion strobes for the datapath)
  // Mem_Ack only completes an access in a BUSY state; elsewhere it is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    dm_grant = 1'b0;
    if_grant = 1'b0;
    if_done  = 1'b0;
    dm_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        dm_grant = (state_next == BUSY_DM);
        if_grant = (state_next == BUSY_IF);
      end
      BUSY_IF: if_done = Mem_Ack;
      BUSY_DM: dm_done = Mem_Ack;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst counter: counts data grants that overtook a waiting fetch.
  // Any IDLE cycle without a fetch pending, or a fetch grant, clears it.
  // ---------------------------------------------------------------------------
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (if_grant) begin
      burst_cnt_next = '0;
    end else if ((state_reg == IDLE) && !IF_Read) begin
      burst_cnt_next = '0;
    end else if (dm_grant && (burst_cnt_reg < BURST_MAX)) begin
      burst_cnt_next = burst_cnt_reg + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered datapath. Memory-side signals are captured on the grant edge
  // and held until the Mem_Ack edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_reg <= '0;
      Mem_Req       <= 1'b0;
      Mem_Write     <= 1'b0;
      Mem_Address   <= '0;
      Mem_WriteData <= '0;
      Mem_ByteEn    <= 4'b0000;
      IF_Ready      <= 1'b0;
      DM_Ready      <= 1'b0;
      IF_DataOut    <= '0;
      DM_DataOut    <= '0;
    end else begin
      burst_cnt_reg <= burst_cnt_next;

      // Ready is high exactly for the RESP cycle.
      IF_Ready <= if_done;
      DM_Ready <= dm_done;

      if (dm_grant) begin
        Mem_Req       <= 1'b1;
        Mem_Write     <= DM_Write;
        Mem_Address   <= DM_Address;
        Mem_WriteData <= DM_WriteData;
        Mem_ByteEn    <= DM_Write ? DM_ByteEn : 4'b1111;
      end else if (if_grant) begin
        Mem_Req     <= 1'b1;
        Mem_Write   <= 1'b0;
        Mem_Address <= IF_Address;
        Mem_ByteEn  <= 4'b1111;
      end else if (if_done || dm_done) begin
        Mem_Req <= 1'b0;
      end

      // DataOut holds its value between accesses; stores load it as well.
      if (if_done) begin
        IF_DataOut <= Mem_ReadData;
      end
      if (dm_done) begin
        DM_DataOut <= Mem_ReadData;
      end
    end
  end

  assign IF_Wait = IF_Read & ~IF_Ready;
  assign DM_Wait = (DM_Read | DM_Write) & ~DM_Ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          IF_Read;
  logic [AW-1:0] IF_Address;
  logic [DW-1:0] IF_DataOut;
  logic          IF_Ready;
  logic          IF_Wait;
  logic          DM_Read;
  logic          DM_Write;
  logic [AW-1:0] DM_Address;
  logic [DW-1:0] DM_WriteData;
  logic [3:0]    DM_ByteEn;
  logic [DW-1:0] DM_DataOut;
  logic          DM_Ready;
  logic          DM_Wait;
  logic          Mem_Req;
  logic          Mem_Write;
  logic [AW-1:0] Mem_Address;
  logic [DW-1:0] Mem_WriteData;
  logic [3:0]    Mem_ByteEn;
  logic [DW-1:0] Mem_ReadData;
  logic          Mem_Ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MAX_DM_BURST(4)
  ) dut (
    .clock        (clk),
    .reset_n      (reset_n),
    .IF_Read      (IF_Read),
    .IF_Address   (IF_Address),
    .IF_DataOut   (IF_DataOut),
    .IF_Ready     (IF_Ready),
    .IF_Wait      (IF_Wait),
    .DM_Read      (DM_Read),
    .DM_Write     (DM_Write),
    .DM_Address   (DM_Address),
    .DM_WriteData (DM_WriteData),
    .DM_ByteEn    (DM_ByteEn),
    .DM_DataOut   (DM_DataOut),
    .DM_Ready     (DM_Ready),
    .DM_Wait      (DM_Wait),
    .Mem_Req      (Mem_Req),
    .Mem_Write    (Mem_Write),
    .Mem_Address  (Mem_Address),
    .Mem_WriteData(Mem_WriteData),
    .Mem_ByteEn   (Mem_ByteEn),
    .Mem_ReadData (Mem_ReadData),
    .Mem_Ack      (Mem_Ack)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
  } grant_t;

  // scoreboard queues
  grant_t        exp_grant[$];
  logic [DW-1:0] exp_if[$];
  logic [DW-1:0] exp_dm[$];
  grant_t        cur_grant;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle_no = 0;
  int n_grants = 0;
  int n_if_ready = 0;
  int n_dm_ready = 0;
  int last_grant_cycle = -1;
  int last_dm_ready_cycle = -1;
  logic prev_req = 1'b0;
  logic prev_if_ready = 1'b0;
  logic prev_dm_ready = 1'b0;

  // memory responder / requester behaviour knobs
  int ack_lat = 0;
  int lat_cnt = 0;
  bit mem_auto = 1'b1;
  bit stray_ack = 1'b0;
  bit if_auto_drop = 1'b1;
  bit dm_auto_drop = 1'b1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 30'h100) return 32'h2402000A;
    return {2'b00, a} ^ 32'hC0DE_5A00;
  endfunction

  // One clock: sample #1 after the edge, score grants/readies, then act as
  // the memory and as the requesters for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle_no++;
    if (Mem_Req && !prev_req) begin
      n_grants++;
      last_grant_cycle = cycle_no;
      cur_grant = '{Mem_Address, Mem_Write, Mem_ByteEn, Mem_WriteData};
      tests_run++;
      if (exp_grant.size() == 0) begin
        tests_failed++;
        $display("FAIL grant_unexpected: got addr=%h write=%b be=%b, required no grant",
                 Mem_Address, Mem_Write, Mem_ByteEn);
      end else begin
        grant_t e;
        e = exp_grant.pop_front();
        if (Mem_Address !== e.addr || Mem_Write !== e.write || Mem_ByteEn !== e.be ||
            (e.write && Mem_WriteData !== e.wdata)) begin
          tests_failed++;
          $display("FAIL grant_fields: got addr=%h write=%b be=%b wdata=%h, required addr=%h write=%b be=%b wdata=%h",
                   Mem_Address, Mem_Write, Mem_ByteEn, Mem_WriteData, e.addr, e.write, e.be, e.wdata);
        end
      end
    end else if (Mem_Req && prev_req) begin
      tests_run++;
      if (Mem_Address !== cur_grant.addr || Mem_Write !== cur_grant.write ||
          Mem_ByteEn !== cur_grant.be || Mem_WriteData !== cur_grant.wdata) begin
        tests_failed++;
        $display("FAIL grant_stable: got addr=%h write=%b be=%b, required addr=%h write=%b be=%b",
                 Mem_Address, Mem_Write, Mem_ByteEn, cur_grant.addr, cur_grant.write, cur_grant.be);
      end
    end

    if (IF_Ready) begin
      n_if_ready++;
      tests_run++;
      if (prev_if_ready) begin
        tests_failed++;
        $display("FAIL if_ready_width: got IF_Ready high 2 cycles, required 1");
      end else if (exp_if.size() == 0) begin
        tests_failed++;
        $display("FAIL if_ready_unexpected: got IF_Ready data=%h, required no pulse", IF_DataOut);
      end else begin
        logic [DW-1:0] e;
        e = exp_if.pop_front();
        if (IF_DataOut !== e) begin
          tests_failed++;
          $display("FAIL if_data: got %h, required %h", IF_DataOut, e);
        end
      end
      if (if_auto_drop) IF_Read = 1'b0;
    end

    if (DM_Ready) begin
      n_dm_ready++;
      last_dm_ready_cycle = cycle_no;
      tests_run++;
      if (prev_dm_ready) begin
        tests_failed++;
        $display("FAIL dm_ready_width: got DM_Ready high 2 cycles, required 1");
      end else if (exp_dm.size() == 0) begin
        tests_failed++;
        $display("FAIL dm_ready_unexpected: got DM_Ready data=%h, required no pulse", DM_DataOut);
      end else begin
        logic [DW-1:0] e;
        e = exp_dm.pop_front();
        if (DM_DataOut !== e) begin
          tests_failed++;
          $display("FAIL dm_data: got %h, required %h", DM_DataOut, e);
        end
      end
      if (dm_auto_drop) begin
        DM_Read  = 1'b0;
        DM_Write = 1'b0;
      end
    end

    prev_req      = Mem_Req;
    prev_if_ready = IF_Ready;
    prev_dm_ready = DM_Ready;

    // memory responder
    if (Mem_Ack) begin
      Mem_Ack = 1'b0;
      lat_cnt = 0;
    end else if (stray_ack) begin
      Mem_Ack      = 1'b1;
      Mem_ReadData = 32'hBAD0_0BAD;
      stray_ack    = 1'b0;
    end else if (Mem_Req && mem_auto) begin
      if (lat_cnt >= ack_lat) begin
        Mem_Ack      = 1'b1;
        Mem_ReadData = mem_word(Mem_Address);
      end else begin
        lat_cnt++;
      end
    end else if (!Mem_Req) begin
      lat_cnt = 0;
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    IF_Read      = 1'b1;
    IF_Address   = '0;
    DM_Read      = 1'b0;
    DM_Write     = 1'b1;
    DM_Address   = '0;
    DM_WriteData = '0;
    DM_ByteEn    = 4'b0000;
    Mem_ReadData = '0;
    Mem_Ack      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({Mem_Req, Mem_Write, IF_Ready, DM_Ready, Mem_ByteEn} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got req=%b wr=%b ifr=%b dmr=%b be=%b, required all 0",
               Mem_Req, Mem_Write, IF_Ready, DM_Ready, Mem_ByteEn);
    end
    tests_run++;
    if (Mem_Address !== '0 || Mem_WriteData !== '0 || IF_DataOut !== '0 || DM_DataOut !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h wd=%h ifd=%h dmd=%h, required 0",
               Mem_Address, Mem_WriteData, IF_DataOut, DM_DataOut);
    end
    tests_run++;
    if (IF_Wait !== 1'b1 || DM_Wait !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_wait: got IF_Wait=%b DM_Wait=%b, required 1 1", IF_Wait, DM_Wait);
    end
    IF_Read  = 1'b0;
    DM_Write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (Mem_Req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got Mem_Req=%b, required 0", Mem_Req);
    end
  endtask

  task automatic test_single_fetch();
    int r0;
    ack_lat      = 3;
    if_auto_drop = 1'b0;
    IF_Address   = 30'h100;
    IF_Read      = 1'b1;
    exp_grant.push_back('{30'h100, 1'b0, 4'hF, 32'h0});
    exp_if.push_back(32'h2402000A);
    r0 = n_if_ready;
    tick();
    tests_run++;
    if (Mem_Req !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_grant_latency: got Mem_Req=%b, required 1", Mem_Req);
    end
    for (int i = 0; i < 20 && n_if_ready == r0; i++) begin
      tests_run++;
      if (IF_Wait !== 1'b1) begin
        tests_failed++;
        $display("FAIL fetch_wait: got IF_Wait=%b, required 1", IF_Wait);
      end
      tick();
    end
    tests_run++;
    if (n_if_ready == r0) begin
      tests_failed++;
      $display("FAIL fetch_timeout: got no IF_Ready, required a pulse");
    end
    tests_run++;
    if (IF_Wait !== 1'b0 || (cycle_no - last_grant_cycle) != 4) begin
      tests_failed++;
      $display("FAIL fetch_ready_timing: got IF_Wait=%b latency=%0d, required 0 and 4",
               IF_Wait, cycle_no - last_grant_cycle);
    end
    IF_Read = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (IF_DataOut !== 32'h2402000A || IF_Ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_hold: got data=%h ready=%b, required 2402000a 0", IF_DataOut, IF_Ready);
    end
    if_auto_drop = 1'b1;
  endtask

  task automatic test_store();
    logic [AW-1:0] addr_t[3];
    logic [DW-1:0] wd_t[3];
    logic [3:0]    be_t[3];
    logic          rd_t[3];
    logic          wr_t[3];
    int r0;
    addr_t = '{30'h40, 30'h41, 30'h42};
    wd_t   = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
    be_t   = '{4'b0011, 4'b1100, 4'b0101};
    rd_t   = '{1'b0, 1'b1, 1'b1};
    wr_t   = '{1'b1, 1'b1, 1'b0};
    ack_lat = 1;
    for (int k = 0; k < 3; k++) begin
      DM_Address   = addr_t[k];
      DM_WriteData = wd_t[k];
      DM_ByteEn    = be_t[k];
      DM_Read      = rd_t[k];
      DM_Write     = wr_t[k];
      exp_grant.push_back('{addr_t[k], wr_t[k], wr_t[k] ? be_t[k] : 4'hF, wd_t[k]});
      exp_dm.push_back(mem_word(addr_t[k]));
      r0 = n_dm_ready;
      tick();
      tests_run++;
      if (DM_Wait !== 1'b1) begin
        tests_failed++;
        $display("FAIL store_wait: got DM_Wait=%b, required 1", DM_Wait);
      end
      for (int i = 0; i < 20 && n_dm_ready == r0; i++) tick();
      tests_run++;
      if (n_dm_ready == r0) begin
        tests_failed++;
        $display("FAIL store_timeout: got no DM_Ready for entry %0d, required a pulse", k);
      end
      repeat (2) tick();
    end
  endtask

  task automatic test_simultaneous();
    int r0;
    ack_lat    = 0;
    IF_Address = 30'h200;
    DM_Address = 30'h300;
    DM_Read    = 1'b1;
    IF_Read    = 1'b1;
    exp_grant.push_back('{30'h300, 1'b0, 4'hF, 32'h0});
    exp_grant.push_back('{30'h200, 1'b0, 4'hF, 32'h0});
    exp_dm.push_back(mem_word(30'h300));
    exp_if.push_back(mem_word(30'h200));
    r0 = n_if_ready;
    for (int i = 0; i < 30 && n_if_ready == r0; i++) tick();
    tests_run++;
    if (n_if_ready == r0) begin
      tests_failed++;
      $display("FAIL simul_timeout: got no IF_Ready, required a pulse");
    end
    tests_run++;
    if (last_grant_cycle != last_dm_ready_cycle + 2) begin
      tests_failed++;
      $display("FAIL simul_if_grant_cycle: got %0d, required %0d",
               last_grant_cycle, last_dm_ready_cycle + 2);
    end
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    int g0;
    ack_lat      = 0;
    dm_auto_drop = 1'b0;
    DM_Address   = 30'h500;
    IF_Address   = 30'h600;
    DM_Read      = 1'b1;
    IF_Read      = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        exp_grant.push_back('{30'h600, 1'b0, 4'hF, 32'h0});
        exp_if.push_back(mem_word(30'h600));
      end else begin
        exp_grant.push_back('{30'h500, 1'b0, 4'hF, 32'h0});
        exp_dm.push_back(mem_word(30'h500));
      end
    end
    g0 = n_grants;
    for (int i = 0; i < 100 && (n_grants - g0) < 7; i++) tick();
    DM_Read = 1'b0;
    tests_run++;
    if ((n_grants - g0) != 7) begin
      tests_failed++;
      $display("FAIL starve_timeout: got %0d grants, required 7", n_grants - g0);
    end
    repeat (6) tick();
    tests_run++;
    if (exp_grant.size() != 0 || exp_if.size() != 0 || exp_dm.size() != 0) begin
      tests_failed++;
      $display("FAIL starve_leftover: got %0d/%0d/%0d pending, required 0/0/0",
               exp_grant.size(), exp_if.size(), exp_dm.size());
    end
    dm_auto_drop = 1'b1;
  endtask

  task automatic test_back_to_back();
    int r0;
    ack_lat      = 0;
    dm_auto_drop = 1'b0;
    // held only through RESP: no second grant
    DM_Address = 30'h700;
    DM_Read    = 1'b1;
    exp_grant.push_back('{30'h700, 1'b0, 4'hF, 32'h0});
    exp_dm.push_back(mem_word(30'h700));
    r0 = n_dm_ready;
    for (int i = 0; i < 20 && n_dm_ready == r0; i++) tick();
    tests_run++;
    if (n_dm_ready == r0 || Mem_Req !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_resp_req: got ready_seen=%0d Mem_Req=%b, required 1 0",
               n_dm_ready - r0, Mem_Req);
    end
    tick();
    tests_run++;
    if (Mem_Req !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_idle_req: got Mem_Req=%b in IDLE, required 0", Mem_Req);
    end
    DM_Read = 1'b0;
    repeat (4) tick();
    // held into IDLE: request is served again
    DM_Address = 30'h701;
    DM_Read    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_grant.push_back('{30'h701, 1'b0, 4'hF, 32'h0});
      exp_dm.push_back(mem_word(30'h701));
    end
    r0 = n_dm_ready;
    for (int i = 0; i < 20 && n_dm_ready == r0; i++) tick();
    tick();
    tick();
    tests_run++;
    if (Mem_Req !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_regrant: got Mem_Req=%b, required 1", Mem_Req);
    end
    for (int i = 0; i < 20 && n_dm_ready < r0 + 2; i++) tick();
    DM_Read = 1'b0;
    tests_run++;
    if (n_dm_ready != r0 + 2) begin
      tests_failed++;
      $display("FAIL held_regrant_count: got %0d readies, required 2", n_dm_ready - r0);
    end
    repeat (3) tick();
    dm_auto_drop = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    int rd0;
    int ri0;
    mem_auto   = 1'b0;
    DM_Address = 30'h800;
    DM_Read    = 1'b1;
    exp_grant.push_back('{30'h800, 1'b0, 4'hF, 32'h0});
    rd0 = n_dm_ready;
    ri0 = n_if_ready;
    tick();
    tick();
    tests_run++;
    if (Mem_Req !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got Mem_Req=%b, required 1", Mem_Req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (Mem_Req !== 1'b0 || IF_Ready !== 1'b0 || DM_Ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got req=%b ifr=%b dmr=%b, required 0 0 0",
               Mem_Req, IF_Ready, DM_Ready);
    end
    DM_Read = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    mem_auto  = 1'b1;
    stray_ack = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (n_dm_ready != rd0 || n_if_ready != ri0 || Mem_Req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_stray_ack: got readies=%0d Mem_Req=%b, required 0 0",
               (n_dm_ready - rd0) + (n_if_ready - ri0), Mem_Req);
    end
    tests_run++;
    if (exp_grant.size() != 0 || exp_if.size() != 0 || exp_dm.size() != 0) begin
      tests_failed++;
      $display("FAIL final_leftover: got %0d/%0d/%0d pending, required 0/0/0",
               exp_grant.size(), exp_if.size(), exp_dm.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
